// File: rtl/pc_sequencer.sv
// Multi-cycle program-counter sequencer: owns the PC, runs fetch/execute against a
// handshaked instruction memory and commits the next PC selected by PCSrc.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] instr_in,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        ex_done,
  input  logic [1:0]  npc_op,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err,
  output logic        misalign_err
);

  // Next-PC select codes, matching the NPC_* encoding used by the control unit.
  localparam logic [1:0] NpcPlus4   = 2'b00;
  localparam logic [1:0] NpcBranch  = 2'b01;
  localparam logic [1:0] NpcJumpImm = 2'b10;
  localparam logic [1:0] NpcJumpReg = 2'b11;

  localparam logic [CNT_W-1:0] WaitLast = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StStart,
    StFetch,
    StExec,
    StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              imem_req_q, imem_req_d;
  logic              fetch_err_q, fetch_err_d;
  logic              misalign_err_q, misalign_err_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

  logic [31:0]       pc_inc;
  logic [31:0]       branch_off;
  logic [31:0]       npc;
  logic              jr_misaligned;

  assign pc_inc        = pc_q + 32'd4;
  assign branch_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jr_misaligned = (npc_op == NpcJumpReg) && (rs_data[1:0] != 2'b00);

  always_comb begin
    npc = pc_inc;
    unique case (npc_op)
      NpcPlus4:   npc = pc_inc;
      NpcBranch:  npc = pc_inc + branch_off;
      NpcJumpImm: npc = {pc_inc[31:28], instr_q[25:0], 2'b00};
      NpcJumpReg: npc = rs_data;
      default:    npc = pc_inc;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    instr_valid_d  = 1'b0;
    imem_req_d     = imem_req_q;
    fetch_err_d    = fetch_err_q;
    misalign_err_d = misalign_err_q;
    wait_cnt_d     = wait_cnt_q;

    unique case (state_q)
      StStart: begin
        state_d    = StFetch;
        imem_req_d = 1'b1;
      end
      StFetch: begin
        // A ready on the last allowed cycle beats the timeout.
        if (imem_ready) begin
          instr_d       = instr_in;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          wait_cnt_d    = '0;
          state_d       = StExec;
        end else if (wait_cnt_q == WaitLast) begin
          fetch_err_d = 1'b1;
          imem_req_d  = 1'b0;
          wait_cnt_d  = '0;
          state_d     = StHalt;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StExec: begin
        if (ex_done) begin
          if (jr_misaligned) begin
            misalign_err_d = 1'b1;
            state_d        = StHalt;
          end else begin
            pc_d       = npc;
            imem_req_d = 1'b1;
            state_d    = StFetch;
          end
        end
      end
      StHalt: begin
        imem_req_d = 1'b0;
      end
      default: begin
        imem_req_d = 1'b0;
        state_d    = StHalt;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StStart;
      pc_q           <= RESET_PC;
      instr_q        <= '0;
      instr_valid_q  <= 1'b0;
      imem_req_q     <= 1'b0;
      fetch_err_q    <= 1'b0;
      misalign_err_q <= 1'b0;
      wait_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      instr_valid_q  <= instr_valid_d;
      imem_req_q     <= imem_req_d;
      fetch_err_q    <= fetch_err_d;
      misalign_err_q <= misalign_err_d;
      wait_cnt_q     <= wait_cnt_d;
    end
  end

  assign pc           = pc_q;
  assign pc_plus4     = pc_inc;
  assign imem_addr    = pc_q;
  assign imem_req     = imem_req_q;
  assign instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign fetch_err    = fetch_err_q;
  assign misalign_err = misalign_err_q;

endmodule
